// File: rtl/fpu_pkg.sv
// Shared types and constants for the multicycle single-precision adder.
package fpu_pkg;
   typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, DONE} state_t;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = 24;

   localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
   localparam logic [31:0]      FP_ZERO = 32'h0;
endpackage

// File: rtl/fpu_unpack.sv
// Splits an IEEE-754 single into sign, exponent and hidden-bit mantissa.
// Exponent field 0 is treated as zero (denormals flushed); exponent 255 is ordinary.
module fpu_unpack
   import fpu_pkg::*;
(
   input  logic [31:0]       word,
   output logic              sign,
   output logic [EXP_W-1:0]  exp,
   output logic [MANT_W-1:0] mant,
   output logic              is_zero
);
   always_comb begin
      sign    = word[31];
      exp     = word[30:FRAC_W];
      is_zero = (word[30:FRAC_W] == '0);
      mant    = is_zero ? '0 : {1'b1, word[FRAC_W-1:0]};
   end
endmodule

// File: rtl/fpu_add_sequencer.sv
// Multicycle IEEE-754 single adder: unpack, one-bit-per-cycle align, add, one-step-per-cycle normalize.
// Truncating, no NaN/Inf inputs; result register holds until the next operation's done pulse.
module fpu_add_sequencer
   import fpu_pkg::*;
#(
   parameter int MAX_ALIGN = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);
   localparam int CNT_W = $clog2(MAX_ALIGN + 1);

   state_t              state_q, state_d;
   logic [31:0]         a_q, a_d, b_q, b_d, result_q, result_d;
   logic                sign_q, sign_d, sub_q, sub_d;
   logic [EXP_W:0]      exp_q, exp_d;
   logic [MANT_W-1:0]   mant_l_q, mant_l_d, mant_s_q, mant_s_d;
   logic [MANT_W:0]     sum_q, sum_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                sa, sb, za, zb;
   logic [EXP_W-1:0]    ea, eb;
   logic [MANT_W-1:0]   ma, mb;

   fpu_unpack u_unpack_a (.word(a_q), .sign(sa), .exp(ea), .mant(ma), .is_zero(za));
   fpu_unpack u_unpack_b (.word(b_q), .sign(sb), .exp(eb), .mant(mb), .is_zero(zb));

   logic                a_is_l;
   logic [EXP_W-1:0]    exp_l, exp_s;
   logic [EXP_W:0]      diff, exp_inc;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      sub_d    = sub_q;
      exp_d    = exp_q;
      mant_l_d = mant_l_q;
      mant_s_d = mant_s_q;
      sum_d    = sum_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      // Magnitude order on raw {exp,frac}; ties pick A, which is harmless either way.
      a_is_l  = (a_q[30:0] >= b_q[30:0]);
      exp_l   = a_is_l ? ea : eb;
      exp_s   = a_is_l ? eb : ea;
      diff    = {1'b0, exp_l} - {1'b0, exp_s};
      exp_inc = exp_q + 9'd1;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            mant_l_d = a_is_l ? ma : mb;
            mant_s_d = a_is_l ? (zb ? '0 : mb) : (za ? '0 : ma);
            sign_d   = a_is_l ? sa : sb;
            sub_d    = sa ^ sb;
            exp_d    = {1'b0, exp_l};
            cnt_d    = (diff > 9'(MAX_ALIGN)) ? CNT_W'(MAX_ALIGN) : diff[CNT_W-1:0];
            state_d  = (cnt_d != '0) ? ALIGN : ADD;
         end
         ALIGN: begin
            mant_s_d = mant_s_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ADD;
         end
         ADD: begin
            sum_d   = sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                            : ({1'b0, mant_l_q} + {1'b0, mant_s_q});
            state_d = NORM;
         end
         NORM: begin
            if (sum_q == '0) begin
               result_d = FP_ZERO;
               state_d  = DONE;
            end else if (sum_q[MANT_W]) begin
               // Carry out: one right shift always lands in range; overflow saturates to infinity.
               result_d = (exp_inc >= {1'b0, EXP_INF}) ? {sign_q, EXP_INF, 23'h0}
                                                       : {sign_q, exp_inc[EXP_W-1:0], sum_q[MANT_W-1:1]};
               state_d  = DONE;
            end else if (sum_q[MANT_W-1]) begin
               result_d = {sign_q, exp_q[EXP_W-1:0], sum_q[FRAC_W-1:0]};
               state_d  = DONE;
            end else if (exp_q == 9'd1) begin
               result_d = FP_ZERO;
               state_d  = DONE;
            end else begin
               sum_d = sum_q << 1;
               exp_d = exp_q - 9'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sign_q   <= 1'b0;
         sub_q    <= 1'b0;
         exp_q    <= '0;
         mant_l_q <= '0;
         mant_s_q <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         result_q <= FP_ZERO;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sign_q   <= sign_d;
         sub_q    <= sub_d;
         exp_q    <= exp_d;
         mant_l_q <= mant_l_d;
         mant_s_q <= mant_s_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;
endmodule

// File: tb/tb_fpu_add_sequencer.sv
// Bench for fpu_add_sequencer: transaction-level reference model plus per-cycle compare.
module tb_fpu_add_sequencer;
   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   always #5 clk = ~clk;

   fpu_add_sequencer #(.MAX_ALIGN(25)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .result(result)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Reference: real-valued-style add on integers following the arithmetic rules, plus cycle cost.
   function automatic void ref_add(input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output int lat);
      logic [31:0] l, s;
      int el, es, ml, ms, cnt, sum, e, n;
      if (x[30:0] >= y[30:0]) begin l = x; s = y; end
      else begin l = y; s = x; end
      el  = int'(l[30:23]);
      es  = int'(s[30:23]);
      ml  = (el == 0) ? 0 : int'({1'b1, l[22:0]});
      ms  = (es == 0) ? 0 : int'({1'b1, s[22:0]});
      cnt = (el - es > 25) ? 25 : el - es;
      ms  = ms >> cnt;
      sum = (l[31] != s[31]) ? ml - ms : ml + ms;
      e   = el;
      r   = 32'h0;
      for (n = 1; n < 64; n++) begin
         if (sum == 0) begin r = 32'h0; break; end
         if (sum >= (1 << 24)) begin
            e = e + 1;
            r = (e >= 255) ? {l[31], 8'hFF, 23'h0} : {l[31], 8'(e), 23'(sum >> 1)};
            break;
         end
         if (sum >= (1 << 23)) begin r = {l[31], 8'(e), 23'(sum)}; break; end
         if (e == 1) begin r = 32'h0; break; end
         sum = sum * 2;
         e   = e - 1;
      end
      lat = 3 + cnt + n;
   endfunction

   // Transaction model: m_k counts edges since acceptance (0 = idle).
   int          m_k = 0, m_lat = 0;
   logic [31:0] m_res = 32'h0, m_pend = 32'h0;
   bit          chk_en = 1'b0;

   always @(posedge clk) begin
      logic [31:0] r;
      int          lt;
      if (reset) begin
         m_k   <= 0;
         m_res <= 32'h0;
      end else if (m_k == 0) begin
         if (start) begin
            ref_add(a, b, r, lt);
            m_pend <= r;
            m_lat  <= lt;
            m_k    <= 1;
         end
      end else if (m_k == m_lat) begin
         m_k <= 0;
      end else begin
         if (m_k + 1 == m_lat) m_res <= m_pend;
         m_k <= m_k + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(m_k != 0));
         chk("done", 32'(done), 32'(m_k != 0 && m_k == m_lat));
         chk("result", result, m_res);
      end
   end

   task automatic do_op(input logic [31:0] ai, input logic [31:0] bi,
                        output logic [31:0] r, output int edges);
      bit got;
      @(negedge clk);
      a = ai; b = bi; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      edges = 1;
      got   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin got = 1'b1; break; end
         @(posedge clk);
         edges++;
      end
      chk("done_seen", 32'(got), 32'd1);
      r = result;
   endtask

   logic [31:0] t_a [6] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h40000000, 32'h00000000, 32'h7F7FFFFF};
   logic [31:0] t_b [6] = '{32'h3F800000, 32'h3E800000, 32'hBF400000, 32'hC0000000, 32'h40400000, 32'h7F7FFFFF};
   logic [31:0] t_r [6] = '{32'h40000000, 32'h3FE00000, 32'h3E800000, 32'h00000000, 32'h40400000, 32'h7F800000};
   int          t_l [6] = '{4, 6, 7, 4, 29, 4};

   initial begin
      logic [31:0] r, mr, ra, rb, rr;
      logic [7:0]  e2;
      int          edges, ml;
      bit          seen;

      reset = 1'b1; start = 1'b0; a = 32'h0; b = 32'h0;
      @(posedge clk);
      #1 chk_en = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", result, 32'h0);

      for (int i = 0; i < 6; i++) begin
         ref_add(t_a[i], t_b[i], mr, ml);
         chk($sformatf("model_res%0d", i), mr, t_r[i]);
         chk($sformatf("model_lat%0d", i), 32'(ml), 32'(t_l[i]));
         do_op(t_a[i], t_b[i], r, edges);
         chk($sformatf("dir_res%0d", i), r, t_r[i]);
         chk($sformatf("dir_lat%0d", i), 32'(edges), 32'(t_l[i]));
      end

      // A second start while busy must be ignored.
      @(negedge clk);
      a = 32'h0; b = 32'h40400000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 a = 32'h3F800000; b = 32'h3F800000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin seen = 1'b1; break; end
      end
      chk("busy_start_done", 32'(seen), 32'd1);
      chk("busy_start_res", result, 32'h40400000);

      // Reset while aligning aborts the operation.
      @(negedge clk);
      a = 32'h0; b = 32'h40400000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_result", result, 32'h0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done !== 1'b0) seen = 1'b1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);

      for (int i = 0; i < 300; i++) begin
         ra = $urandom();
         rr = $urandom();
         case ($urandom_range(0, 4))
            0: rb = $urandom();
            1: rb = ra ^ 32'h80000000;
            2: begin
               e2 = ra[30:23] + 8'($urandom_range(0, 3));
               rb = {rr[31], e2, rr[22:0]};
            end
            3: rb = {rr[31], 8'h00, rr[22:0]};
            default: begin
               ra[30:23] = 8'($urandom_range(1, 254));
               rb = {rr[31], 8'($urandom_range(1, 254)), rr[22:0]};
            end
         endcase
         if ($urandom_range(0, 1) == 1) begin
            r = ra; ra = rb; rb = r;
         end
         ref_add(ra, rb, mr, ml);
         do_op(ra, rb, r, edges);
         chk("rand_res", r, mr);
         chk("rand_lat", 32'(edges), 32'(ml));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
